// File: rtl/term_ring_ctrl.sv
// term_ring_ctrl: character ring-buffer controller for a text terminal.
// Accepts ASCII characters over a valid/ready handshake and drives the
// write port of an external char RAM. It handles cursor advance, newline,
// backspace, line wrap and per-line clearing. It also keeps a scrollback
// view offset and maps display (x, y) to a RAM read address.
// Optional feature: define TERM_RING_INIT_CLEAR_EN to sweep the whole RAM
// with spaces after reset, before the first character is accepted.
module term_ring_ctrl #(
    parameter int COLS  = 70,
    parameter int ROWS  = 30,
    parameter int LINES = 90,
    parameter int XW    = 7,
    parameter int YW    = 5,
    parameter int LW    = 7,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    output logic          char_ready,
    input  logic          scroll_up,
    input  logic          scroll_down,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [XW-1:0] disp_x,
    input  logic [YW-1:0] disp_y,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [LW-1:0] view_start,
    output logic [XW-1:0] cur_x,
    output logic [LW-1:0] cur_line
);

    localparam int LW1 = LW + 1;
    localparam logic [LW:0] LINES_W = LW1'(LINES);
    localparam logic [LW:0] ROWS_W  = LW1'(ROWS);
    localparam logic [7:0]  SPACE   = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUT,
        S_CLEAR,
        S_INIT
    } state_t;

`ifdef TERM_RING_INIT_CLEAR_EN
    localparam state_t RST_STATE = S_INIT;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t        state_q, state_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [LW-1:0] cur_line_q, cur_line_d;
    logic [LW-1:0] back_q, back_d;
    logic [LW:0]   filled_q, filled_d;
    logic [XW-1:0] clr_x_q, clr_x_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          char_ready_q, char_ready_d;

    logic [LW-1:0] line_inc;
    logic [LW:0]   maxback;
    logic [LW:0]   view_off;
    logic [LW:0]   view_raw;
    logic [LW:0]   row_sum;
    logic [LW:0]   row_wrap;
    logic          do_newline;

    // Flat RAM address of a (ring line, column) pair.
    function automatic logic [AW-1:0] line_addr(input logic [LW-1:0] line,
                                                input logic [XW-1:0] x);
        return AW'(line) * AW'(COLS) + AW'(x);
    endfunction

    // View geometry and read-address mapping; the modulo-LINES wraps need at
    // most one conditional add or subtract because every operand is already
    // reduced below LINES.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        line_inc = (cur_line_q == LW'(LINES - 1)) ? '0 : cur_line_q + 1'b1;
        maxback  = (filled_q > ROWS_W) ? filled_q - ROWS_W : '0;
        view_off = LW1'(ROWS - 1) + {1'b0, back_q};
        if ({1'b0, cur_line_q} >= view_off) begin
            view_raw = {1'b0, cur_line_q} - view_off;
        end else begin
            view_raw = {1'b0, cur_line_q} + LINES_W - view_off;
        end
        view_start = (filled_q > ROWS_W) ? view_raw[LW-1:0] : '0;

        row_sum  = {1'b0, view_start} + LW1'(disp_y);
        row_wrap = (row_sum >= LINES_W) ? row_sum - LINES_W : row_sum;
        rd_valid = (int'(disp_x) < COLS) && (int'(disp_y) < ROWS);
        rd_addr  = rd_valid ? line_addr(row_wrap[LW-1:0], disp_x) : '0;
    end

    // Next-state logic: scroll handling, handshake decode, clear/init sweeps.
    always_comb begin
        state_d      = state_q;
        cur_x_d      = cur_x_q;
        cur_line_d   = cur_line_q;
        back_d       = back_q;
        filled_d     = filled_q;
        clr_x_d      = clr_x_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        char_ready_d = char_ready_q;
        do_newline   = 1'b0;

        // Scrolling is honoured in every state; simultaneous pulses cancel.
        if (scroll_up && !scroll_down && ({1'b0, back_q} < maxback)) begin
            back_d = back_q + 1'b1;
        end else if (scroll_down && !scroll_up && (back_q != '0)) begin
            back_d = back_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                char_ready_d = 1'b1;
                if (char_valid && char_ready_q) begin
                    // Every accepted code passes through PUT so ready always
                    // drops for at least one cycle after acceptance.
                    char_ready_d = 1'b0;
                    state_d      = S_PUT;
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = line_addr(cur_line_q, cur_x_q);
                        wr_data_d = char_data;
                        cur_x_d   = cur_x_q + 1'b1;
                    end else if (char_data == 8'h0A) begin
                        do_newline = 1'b1;
                    end else if (char_data == 8'h08 && cur_x_q != '0) begin
                        cur_x_d   = cur_x_q - 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = line_addr(cur_line_q, cur_x_q - 1'b1);
                        wr_data_d = SPACE;
                    end
                end
            end
            S_PUT: begin
                if (cur_x_q == XW'(COLS)) begin
                    do_newline = 1'b1;
                end else begin
                    state_d      = S_IDLE;
                    char_ready_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (clr_x_q == XW'(COLS - 1)) begin
                    state_d      = S_IDLE;
                    char_ready_d = 1'b1;
                end else begin
                    clr_x_d   = clr_x_q + 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = SPACE;
                end
            end
            default: begin
`ifdef TERM_RING_INIT_CLEAR_EN
                // Sweep every RAM address once, ascending, then go idle.
                if (!wr_en_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = SPACE;
                end else if (wr_addr_q == AW'(LINES * COLS - 1)) begin
                    state_d      = S_IDLE;
                    char_ready_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = SPACE;
                end
`else
                state_d      = S_IDLE;
                char_ready_d = 1'b1;
`endif
            end
        endcase

        // Explicit or wrap-induced newline: advance the ring, snap the view to
        // the bottom and issue the first space write of the new line.
        if (do_newline) begin
            cur_x_d      = '0;
            cur_line_d   = line_inc;
            filled_d     = (filled_q == LINES_W) ? filled_q : filled_q + 1'b1;
            back_d       = '0;
            clr_x_d      = '0;
            state_d      = S_CLEAR;
            char_ready_d = 1'b0;
            wr_en_d      = 1'b1;
            wr_addr_d    = line_addr(line_inc, '0);
            wr_data_d    = SPACE;
        end
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q      <= RST_STATE;
            cur_x_q      <= '0;
            cur_line_q   <= '0;
            back_q       <= '0;
            filled_q     <= LW1'(1);
            clr_x_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= SPACE;
            char_ready_q <= RST_READY;
        end else begin
            state_q      <= state_d;
            cur_x_q      <= cur_x_d;
            cur_line_q   <= cur_line_d;
            back_q       <= back_d;
            filled_q     <= filled_d;
            clr_x_q      <= clr_x_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            char_ready_q <= char_ready_d;
        end
    end

    assign char_ready = char_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cur_x      = cur_x_q;
    assign cur_line   = cur_line_q;

endmodule

// File: tb/tb_term_ring_ctrl.sv
// Directed testbench for term_ring_ctrl with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_term_ring_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        scroll_up = 1'b0;
    logic        scroll_down = 1'b0;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  disp_x = '0;
    logic [4:0]  disp_y = '0;
    logic [12:0] rd_addr;
    logic        rd_valid;
    logic [6:0]  view_start;
    logic [6:0]  cur_x;
    logic [6:0]  cur_line;

    int n_checks = 0;
    int n_fail   = 0;

    term_ring_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .scroll_up   (scroll_up),
        .scroll_down (scroll_down),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .disp_x      (disp_x),
        .disp_y      (disp_y),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .view_start  (view_start),
        .cur_x       (cur_x),
        .cur_line    (cur_line)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!char_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check("ready_timeout", 32'(char_ready), 1);
    endtask

    // Returns at the falling edge of the first cycle after acceptance.
    task automatic send_char(input logic [7:0] c);
        wait_ready();
        char_valid = 1'b1;
        char_data  = c;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    // Starting at a falling edge inside CLEAR, scan until ready returns,
    // counting busy cycles and correct space writes from addr first upward.
    task automatic clear_scan(input int first, output int low, output int good);
        int k = 0;
        low  = 0;
        good = 0;
        while (!char_ready && k < 300) begin
            low++;
            if (wr_en && wr_addr == 13'(first + k) && wr_data == 8'h20) good++;
            k++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
`ifdef TERM_RING_INIT_CLEAR_EN
        begin
            int cnt = 0;
            int good = 0;
            int n = 0;
            @(negedge clk);
            while (!char_ready && n < 7000) begin
                if (wr_en) begin
                    if (wr_addr == 13'(cnt) && wr_data == 8'h20) good++;
                    cnt++;
                end
                n++;
                @(negedge clk);
            end
            check("init_writes", cnt, 6300);
            check("init_good", good, 6300);
        end
`endif
    endtask

    task automatic pulse_scroll(input logic up, input logic down);
        scroll_up   = up;
        scroll_down = down;
        @(negedge clk);
        scroll_up   = 1'b0;
        scroll_down = 1'b0;
    endtask

    initial begin
        int low;
        int good;

        // Reset state.
        @(negedge clk);
        do_reset();
        check("rst_ready", char_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_cur_x", cur_x, 0);
        check("rst_cur_line", cur_line, 0);
        check("rst_view", view_start, 0);

        // Single printable char.
        send_char(8'h41);
        check("a_wr_en", wr_en, 1);
        check("a_wr_addr", wr_addr, 0);
        check("a_wr_data", wr_data, 8'h41);
        check("a_cur_x", cur_x, 1);
        check("a_ready_low", char_ready, 0);
        @(negedge clk);
        check("a_wr_off", wr_en, 0);
        check("a_ready_back", char_ready, 1);

        // Line wrap after COLS printable chars.
        do_reset();
        for (int i = 0; i < 69; i++) send_char(8'h61 + 8'(i % 26));
        wait_ready();
        check("wrap_x69", cur_x, 69);
        send_char(8'h5A);
        check("wrap_addr", wr_addr, 69);
        check("wrap_data", wr_data, 8'h5A);
        @(negedge clk);
        check("wrap_line", cur_line, 1);
        check("wrap_x0", cur_x, 0);
        clear_scan(70, low, good);
        check("wrap_ready_low", low + 1, 71);
        check("wrap_clear_writes", good, 70);

        // 31 newlines, view and read path.
        do_reset();
        for (int i = 0; i < 31; i++) send_char(8'h0A);
        wait_ready();
        check("nl31_line", cur_line, 31);
        check("nl31_view", view_start, 2);
        disp_y = 5'd29; disp_x = 7'd5;
        @(negedge clk);
        check("rd_addr_2175", rd_addr, 2175);
        check("rd_valid_in", rd_valid, 1);
        disp_y = 5'd0; disp_x = 7'd0;
        @(negedge clk);
        check("rd_addr_row0", rd_addr, 140);
        disp_x = 7'd70;
        @(negedge clk);
        check("rd_valid_x70", rd_valid, 0);
        check("rd_addr_inval", rd_addr, 0);
        disp_x = 7'd0; disp_y = 5'd30;
        @(negedge clk);
        check("rd_valid_y30", rd_valid, 0);

        // Scrollback saturation and cancellation.
        repeat (3) pulse_scroll(1'b1, 1'b0);
        check("scroll_sat_view", view_start, 0);
        pulse_scroll(1'b1, 1'b1);
        check("scroll_both", view_start, 0);
        pulse_scroll(1'b0, 1'b1);
        check("scroll_down", view_start, 1);
        send_char(8'h0A);
        wait_ready();
        check("scroll_snap", view_start, 3);

        // Ring wrap after LINES newlines.
        do_reset();
        for (int i = 0; i < 89; i++) send_char(8'h0A);
        send_char(8'h0A);
        check("ring_line", cur_line, 0);
        clear_scan(0, low, good);
        check("ring_clear_low", low, 70);
        check("ring_clear_writes", good, 70);
        check("ring_view", view_start, 61);
        disp_x = 7'd3; disp_y = 5'd29;
        @(negedge clk);
        check("ring_rd_wrap", rd_addr, 3);
        disp_y = 5'd28;
        @(negedge clk);
        check("ring_rd_last", rd_addr, 6233);

        // Backspace at column 0 is a no-op.
        send_char(8'h08);
        check("bs0_wr_en", wr_en, 0);
        check("bs0_cur_x", cur_x, 0);
        check("bs0_line", cur_line, 0);
        // Backspace after a char blanks it.
        send_char(8'h42);
        check("b_addr", wr_addr, 0);
        send_char(8'h08);
        check("bs_wr_en", wr_en, 1);
        check("bs_addr", wr_addr, 0);
        check("bs_data", wr_data, 8'h20);
        check("bs_cur_x", cur_x, 0);
        // Unknown control code is consumed without a write.
        send_char(8'h07);
        check("ign_wr_en", wr_en, 0);
        check("ign_ready", char_ready, 0);
        check("ign_cur_x", cur_x, 0);

        // Reset in the middle of a CLEAR sweep.
        wait_ready();
        send_char(8'h0A);
        repeat (19) @(negedge clk);
        check("mid_clear_busy", wr_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_line", cur_line, 0);
`ifdef TERM_RING_INIT_CLEAR_EN
        check("mid_rst_ready", char_ready, 0);
`else
        check("mid_rst_ready", char_ready, 1);
`endif
        do_reset();
        check("post_rst_ready", char_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/term_ring_ctrl.md
Name: term_ring_ctrl

Overview:
- Sequential successor to the UI text-terminal address logic.
- Owns the character ring buffer: accepts ASCII chars over a valid/ready handshake and drives write ports to the char RAM.
- Handles cursor advance, newline, backspace, line wrap and per-line clearing.
- Keeps a scrollback view offset and maps display (x, y) to a RAM read address.
- Generalised over columns, visible rows and ring depth.

Parameters:
- COLS, 70: characters per line.
- ROWS, 30: visible display rows.
- LINES, 90: ring buffer depth in lines (LINES >= ROWS).
- XW, 7: width of column coordinates.
- YW, 5: width of display row coordinate.
- LW, 7: width of line index.
- AW, 13: RAM address width (LINES*COLS <= 2^AW).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- char_valid  in  1  input char present
- char_data  in  8  ASCII code
- char_ready  out  1  controller can accept a char
- scroll_up  in  1  one-cycle pulse: view one line older
- scroll_down  in  1  one-cycle pulse: view one line newer
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- wr_data  out  8  RAM write data
- disp_x  in  XW  display column being fetched
- disp_y  in  YW  display row being fetched
- rd_addr  out  AW  RAM read address (combinational)
- rd_valid  out  1  disp_x < COLS and disp_y < ROWS
- view_start  out  LW  ring line shown on display row 0
- cur_x  out  XW  cursor column
- cur_line  out  LW  cursor ring line

Behaviour:
- Clocking and reset:
  - All state is updated on the rising edge of clk.
  - rst_n = 0 sampled at an edge resets the block synchronously. This applies even mid-CLEAR/INIT, aborting the sweep.
- Reset values:
  - cur_x = 0, cur_line = 0, back = 0, filled = 1.
  - wr_en = 0, wr_addr = 0, wr_data = 0x20.
  - state = IDLE and char_ready = 1 (INIT and 0 under INIT_CLEAR_EN).
- Address rule: addr(line, x) = line*COLS + x, width AW. Line indices wrap modulo LINES, computed without a divider: at most one conditional subtract or add of LINES.
- States:
  - IDLE: char_ready = 1. A handshake (char_valid & char_ready) decodes char_data.
  - PUT: one cycle.
  - CLEAR: COLS cycles.
  - INIT: only when the optional feature is enabled.
- Printable char (0x20–0x7E):
  - Next cycle, wr_en = 1 with wr_addr = addr(cur_line, cur_x) and wr_data = char_data; cur_x increments. Write latency is 1 cycle.
  - If the new cur_x == COLS, an implicit newline follows immediately (enter CLEAR).
- Newline (0x0A), or an implicit newline from line wrap:
  - cur_x = 0 and cur_line = (cur_line + 1) mod LINES.
  - filled increments, saturating at LINES; back = 0 (snap to bottom).
  - Enter CLEAR: COLS consecutive writes of 0x20 to addr(new cur_line, 0..COLS-1), then return to IDLE. char_ready = 0 throughout.
- Backspace (0x08):
  - If cur_x > 0: cur_x decrements and 0x20 is written at the new position (one write, latency 1).
  - At cur_x = 0: no-op, with no write and no line change.
- Other codes: consumed, ignored, no write.
- char_ready: deasserts in the cycle after acceptance and reasserts once back in IDLE.
- View:
  - maxback = filled - ROWS if filled > ROWS, else 0.
  - scroll_up increments back up to maxback; scroll_down decrements back down to 0. Both pulses in the same cycle give no change.
  - Scroll pulses are honoured in every state.
  - view_start = 0 while filled <= ROWS. Otherwise view_start = (cur_line - (ROWS-1) - back) mod LINES.
- Read path:
  - rd_addr = addr((view_start + disp_y) mod LINES, disp_x).
  - When rd_valid = 0, rd_addr = 0.

Optional Feature:
- Macro TERM_RING_INIT_CLEAR_EN.
- Defined:
  - After reset the block enters INIT and writes 0x20 to every address 0..LINES*COLS-1, one per cycle, ascending.
  - char_ready = 0 during INIT; IDLE follows the last write.
- Undefined: reset goes straight to IDLE and RAM contents are not touched.

Test Plan:
- Write 'A' (0x41) after reset -> next cycle wr_en = 1, wr_addr = 0, wr_data = 0x41; cur_x = 1.
- 70 printable chars -> 70th write at addr 69, then cur_line = 1, cur_x = 0, 70 writes of 0x20 to addrs 70..139; char_ready low exactly 70 cycles plus the PUT cycle.
- 31 newlines -> cur_line = 31, filled = 32, view_start = 2; disp_y = 29, disp_x = 5 -> rd_addr = 2175, rd_valid = 1; disp_x = 70 -> rd_valid = 0.
- At filled = 32: three scroll_up pulses -> back saturates at 2 and view_start = 0; then scroll_up and scroll_down in the same cycle -> unchanged; one newline -> back = 0 and view_start = 3.
- 90 newlines from reset -> cur_line wraps to 0, CLEAR writes addrs 0..69, filled = 90, view_start = 61; backspace at cur_x = 0 -> no write.
- Reset asserted mid-CLEAR (cycle 20) -> next cycle wr_en = 0, cur_line = 0, char_ready = 1. With TERM_RING_INIT_CLEAR_EN: 6300 writes of 0x20 to addrs 0..6299 before char_ready rises.
